pattern_fsm: RTL and testbench

//  Parametrised serial pattern-detector FSM; successor to the fixed two-flavour (Moore/Mealy) test FSMs.

---
 rtl/pattern_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_pattern_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_fsm.sv
// -----------------------------------------------------------------------------
// pattern_fsm
//   Parametrised serial pattern detector. It watches a 1-bit stream qualified
//   by en and reports every occurrence of a PAT_W-bit pattern. The pattern's
//   MSB, PATTERN[PAT_W-1], is the first bit received.
//
//   State index k means "the last k sampled bits equal the first k bits of
//   PATTERN". The next-state table comes from the KMP prefix/suffix rule. It
//   is built entirely at elaboration by constant functions, so the run-time
//   logic is only a table lookup on {state, din}.
//
//   MEALY = 0 : Moore timing. There is an extra state S(PAT_W) that means a
//               full match. match is registered and is high while the FSM
//               sits in S(PAT_W).
//   MEALY = 1 : Mealy timing. match is combinational and asserts in the same
//               cycle as the last pattern bit. After a full match the FSM
//               goes straight to the fallback state.
//   OVERLAP   : 1 lets the bits of a match be reused by the next match.
//               0 consumes them, so detection restarts from S0.
//
// Ports
//   clk      in   rising-edge clock
//   rstn     in   asynchronous active-low reset
//   en       in   din is valid this cycle; the FSM only advances when en=1
//   din      in   serial data bit
//   clr      in   synchronous clear of state, count and cnt_ovf;
//                 takes priority over en
//   match    out  detection indication (Moore: registered, Mealy: combinational)
//   state    out  current state index k (debug view of the FSM)
//   count    out  saturating detection counter
//   cnt_ovf  out  sticky flag: a detection arrived while count was all-ones
//
// Handshake: this block has no back-pressure. A bit is consumed on every
// rising edge where rstn=1 and en=1. With en=0, all state holds.
// -----------------------------------------------------------------------------
module pattern_fsm #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               MEALY   = 1'b0,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  localparam int              SW      = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             match,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] count,
  output logic             cnt_ovf
);

  // Number of table rows. This is every value the state index can encode;
  // rows beyond PAT_W are unreachable and simply return to S0.
  localparam int NT = 2 ** SW;
  localparam logic [SW-1:0] FULL = SW'(PAT_W);

  typedef logic [SW-1:0] state_t;

  // ---------------------------------------------------------------------------
  // Elaboration-time helpers. Bit strings are held LSB-aligned in a 17-bit
  // vector, with bit 0 as the most recently received bit.
  // ---------------------------------------------------------------------------

  // First k bits of PATTERN as a string (the newest bit is PATTERN[PAT_W-k]).
  function automatic logic [16:0] prefix_str(input int k);
    logic [16:0] s;
    s = '0;
    for (int i = 0; i < 17; i++) begin
      if (i < k) s[i] = PATTERN[PAT_W-k+i];
    end
    return s;
  endfunction

  // Longest proper suffix of the len-bit string s that is also a prefix of
  // PATTERN. Its length can never exceed PAT_W.
  function automatic int fallback(input logic [16:0] s, input int len);
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j < len; j++) begin
      if (j <= PAT_W) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          if (s[i] != PATTERN[PAT_W-j+i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Moore-style transition from S_k on bit d. A return value of PAT_W means
  // that this bit completes a detection.
  function automatic int raw_next(input int k, input logic d);
    logic [16:0] s;
    int kk;
    kk = k;
    if (k >= PAT_W) begin
      if (OVERLAP) begin
        // Keep the whole matched pattern as history for the next bit.
        s = prefix_str(PAT_W);
        s = {s[15:0], d};
        return fallback(s, PAT_W + 1);
      end
      // Matched bits are consumed, so continue as if the FSM were in S0.
      kk = 0;
    end
    if (d == PATTERN[PAT_W-1-kk]) return kk + 1;
    s = prefix_str(kk);
    s = {s[15:0], d};
    return fallback(s, kk + 1);
  endfunction

  // Actual next state. Mealy skips S(PAT_W) and goes straight to the state
  // that Moore reaches one bit later.
  function automatic int next_state(input int k, input logic d);
    int r;
    r = raw_next(k, d);
    if (MEALY && (r == PAT_W)) begin
      r = OVERLAP ? fallback(prefix_str(PAT_W), PAT_W) : 0;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Transition and detection tables, one row per state index.
  // ---------------------------------------------------------------------------
  state_t nxt_tab0 [NT];
  state_t nxt_tab1 [NT];
  logic   hit_tab0 [NT];
  logic   hit_tab1 [NT];

  for (genvar k = 0; k < NT; k++) begin : g_tab
    localparam bit LIVE = (k <= PAT_W);
    localparam int N0   = LIVE ? next_state(k, 1'b0) : 0;
    localparam int N1   = LIVE ? next_state(k, 1'b1) : 0;
    localparam bit H0   = LIVE && (raw_next(k, 1'b0) == PAT_W);
    localparam bit H1   = LIVE && (raw_next(k, 1'b1) == PAT_W);
    assign nxt_tab0[k] = SW'(N0);
    assign nxt_tab1[k] = SW'(N1);
    assign hit_tab0[k] = H0;
    assign hit_tab1[k] = H1;
  end

  // ---------------------------------------------------------------------------
  // Run-time datapath
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           nxt;
  logic             hit;
  logic             match_q;
  logic             mealy_match;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  always_comb begin
    nxt = nxt_tab0[state_q];
    hit = hit_tab0[state_q];
    if (din) begin
      nxt = nxt_tab1[state_q];
      hit = hit_tab1[state_q];
    end
  end

  // Single FSM/counter register block. Priority is reset, then clr, then en.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= '0;
      match_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      // A detection in the clr cycle is dropped on purpose.
      state_q <= '0;
      match_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      state_q <= nxt;
      // Only Moore ever enters FULL, so this flop stays 0 in Mealy mode.
      match_q <= (nxt == FULL);
      if (hit) begin
        if (&count_q) begin
          ovf_q <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  // Mealy indication: the current bit completes the pattern. It is gated by
  // rstn so that it stays low while the block is held in reset, and it is
  // deliberately not gated by clr.
  assign mealy_match = rstn & en & hit;

  assign match   = MEALY ? mealy_match : match_q;
  assign state   = state_q;
  assign count   = count_q;
  assign cnt_ovf = ovf_q;

endmodule

// File: tb/tb_pattern_fsm.sv
module tb_pattern_fsm;

  localparam int         PW  = 4;
  localparam logic [3:0] PAT = 4'b1011;
  localparam int         NI  = 5;
  localparam int         EW  = 13;  // {match, state[2:0], count[7:0], ovf}
  localparam int         W   = NI * EW;

  logic clk;
  logic rstn, en, din, clr;

  logic       m0, m1, m2, m3, m4;
  logic [2:0] s0, s1, s2, s3, s4;
  logic [7:0] c0, c1, c2, c3;
  logic [1:0] c4;
  logic       o0, o1, o2, o3, o4;

  // ---------------- DUT instances ----------------
  // 0: Moore/overlap  1: Moore/no-overlap  2: Mealy/overlap
  // 3: Mealy/no-overlap  4: Moore/overlap with a 2-bit counter
  pattern_fsm #(.PAT_W(PW), .PATTERN(PAT), .MEALY(1'b0), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .rstn(rstn), .en(en), .din(din), .clr(clr),
    .match(m0), .state(s0), .count(c0), .cnt_ovf(o0));
  pattern_fsm #(.PAT_W(PW), .PATTERN(PAT), .MEALY(1'b0), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .rstn(rstn), .en(en), .din(din), .clr(clr),
    .match(m1), .state(s1), .count(c1), .cnt_ovf(o1));
  pattern_fsm #(.PAT_W(PW), .PATTERN(PAT), .MEALY(1'b1), .OVERLAP(1'b1), .CNT_W(8)) u2 (
    .clk(clk), .rstn(rstn), .en(en), .din(din), .clr(clr),
    .match(m2), .state(s2), .count(c2), .cnt_ovf(o2));
  pattern_fsm #(.PAT_W(PW), .PATTERN(PAT), .MEALY(1'b1), .OVERLAP(1'b0), .CNT_W(8)) u3 (
    .clk(clk), .rstn(rstn), .en(en), .din(din), .clr(clr),
    .match(m3), .state(s3), .count(c3), .cnt_ovf(o3));
  pattern_fsm #(.PAT_W(PW), .PATTERN(PAT), .MEALY(1'b0), .OVERLAP(1'b1), .CNT_W(2)) u4 (
    .clk(clk), .rstn(rstn), .en(en), .din(din), .clr(clr),
    .match(m4), .state(s4), .count(c4), .cnt_ovf(o4));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rstn = 1'b0;
    en   = 1'b0;
    din  = 1'b0;
    clr  = 1'b0;
  end

  // ---------------- instance configuration ----------------
  function automatic bit is_mealy(input int i);
    return (i == 2) || (i == 3);
  endfunction
  function automatic bit is_ovl(input int i);
    return !((i == 1) || (i == 3));
  endfunction
  function automatic int cmax(input int i);
    return (i == 4) ? 3 : 255;
  endfunction

  // ---------------- reference model (bit-history level) ----------------
  logic [15:0] hb [NI];  // recent sampled bits, bit 0 = newest
  int          hl [NI];  // number of valid history bits
  int          mc [NI];  // detection count
  bit          mo [NI];  // overflow flag
  bit          jm [NI];  // last bit completed a consumed (non-overlap) match

  // Length of the longest suffix of the history (at most lim bits) that equals
  // the start of the pattern.
  function automatic int suf_pre(input logic [15:0] h, input int len, input int lim);
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k <= lim; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          if (h[i] != PAT[PW-k+i]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      hb[i] = '0;
      hl[i] = 0;
      mc[i] = 0;
      mo[i] = 1'b0;
      jm[i] = 1'b0;
    end
  endtask

  task automatic model_bit(input logic d);
    for (int i = 0; i < NI; i++) begin
      hb[i] = {hb[i][14:0], d};
      if (hl[i] < 16) hl[i]++;
      jm[i] = 1'b0;
      if (hl[i] >= PW && hb[i][3:0] == PAT) begin
        if (mc[i] == cmax(i)) mo[i] = 1'b1;
        else mc[i]++;
        if (!is_ovl(i)) begin
          hl[i] = 0;
          jm[i] = 1'b1;
        end
      end
    end
  endtask

  // Values that the model expects to be visible during the current cycle.
  function automatic logic [W-1:0] model_expect(input bit r, input bit e, input logic d);
    logic [W-1:0] v;
    logic [EW-1:0] x;
    logic [15:0] t;
    int st;
    bit mt;
    v = '0;
    for (int i = 0; i < NI; i++) begin
      if (is_mealy(i)) begin
        st = suf_pre(hb[i], hl[i], PW - 1);
        t  = {hb[i][14:0], d};
        mt = r && e && ((hl[i] + 1) >= PW) && (t[3:0] == PAT);
      end else begin
        st = jm[i] ? PW : suf_pre(hb[i], hl[i], PW);
        mt = (st == PW);
      end
      x = {mt, 3'(st), 8'(mc[i]), mo[i]};
      v[i*EW +: EW] = x;
    end
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  function automatic logic [EW-1:0] act(input int i);
    logic [EW-1:0] a;
    case (i)
      0:       a = {m0, s0, c0, o0};
      1:       a = {m1, s1, c1, o1};
      2:       a = {m2, s2, c2, o2};
      3:       a = {m3, s3, c3, o3};
      default: a = {m4, s4, 6'b0, c4, o4};
    endcase
    return a;
  endfunction

  task automatic chk(input string nm, input int i, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", nm, i, cyc, got, want);
    end
  endtask

  // Monitor: pops one expectation per cycle and samples away from the active edge.
  initial begin
    logic [W-1:0] ev;
    logic [EW-1:0] a, x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          a = act(i);
          x = ev[i*EW +: EW];
          chk("match", i, int'(a[12]),    int'(x[12]));
          chk("state", i, int'(a[11:9]),  int'(x[11:9]));
          chk("count", i, int'(a[8:1]),   int'(x[8:1]));
          chk("ovf",   i, int'(a[0]),     int'(x[0]));
        end
        cyc++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit e, input logic d, input bit c);
    rstn = r;
    en   = e;
    din  = d;
    clr  = c;
    if (!r) model_reset();
    exp_q.push_back(model_expect(r, e, d));
    if (r) begin
      if (c) model_reset();
      else if (e) model_bit(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    logic [31:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, b[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit r, e, c;
    logic d;
    model_reset();
    @(posedge clk);
    #1;
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Overlap vs non-overlap on 1011011; en=0 afterwards holds the Moore match
    send_bits(32'b1011011, 7);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    // KMP fallbacks on 1101011
    send_bits(32'b1101011, 7);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    // Five overlapping detections saturate the 2-bit counter
    send_bits(32'b1011011011011011, 16);
    idle(1);
    // Detection in the clr cycle is not counted
    send_bits(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    // en gaps inside the pattern
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    // Reset mid-pattern discards the partial match
    send_bits(32'b101, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom_range(0, 199) != 0);
      c = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      step(r, e, d, c);
    end
    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
